fpga_spi_target: RTL and testbench

- SPI responder inside the FPGA that terminates the gated MCU SPI link (CLK/MOSI/NSS) arriving through the CPLD, and drives MISO and INT back to it.
- Oversamples SPI on the FPGA system clock and converts frames into single-cycle register read/write strobes.
- Uses mode 0, MSB first, with a command byte followed by auto-incrementing data bytes.
- Holds sticky interrupt flags and drives the INT line.

---
 rtl/fpga_spi_target.sv | 214 +++++++++++++++++++++
 tb/tb_fpga_spi_target.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_spi_target.sv
// SPI mode-0 responder: oversamples the CPLD-gated SPI link, turns frames into
// single-cycle register read/write strobes and owns the sticky interrupt flags.
module fpga_spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  INT_ADDR    = 7'h7F
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SPI_CLK_IN,
    input  logic       SPI_MOSI_IN,
    input  logic       SPI_NSS_IN,
    output logic       SPI_MISO_OUT,
    output logic       SPI_MISO_OE,
    output logic       SPI_INT_OUT,
    output logic [6:0] REG_ADDR,
    output logic       REG_WR,
    output logic [7:0] REG_WDATA,
    output logic       REG_RD,
    input  logic [7:0] REG_RDATA,
    input  logic [7:0] IRQ_IN,
    output logic       FRAME_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, nss_sync_q;
    logic sclk_prev_q, nss_prev_q;
    logic sclk_s, mosi_s, nss_s;
    logic sclk_rise, sclk_fall, nss_rise, nss_fall;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic       skip_q, skip_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rd_q, rd_d;
    logic       rd_slot_q, rd_slot_d;
    logic       ld_q, ld_d;
    logic       ld_int_q, ld_int_d;
    logic [7:0] pend_q, pend_d;
    logic       int_q, int_d;
    logic       ferr_q, ferr_d;

    logic [7:0] rx_byte;
    logic [6:0] rd_addr;
    logic [7:0] clr;

    // NSS chain resets low so a select already held low after reset is not seen as a new frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            nss_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            nss_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK_IN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI_IN};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], SPI_NSS_IN};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign nss_s     = nss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign nss_rise  = nss_s & ~nss_prev_q;
    assign nss_fall  = ~nss_s & nss_prev_q;

    assign rx_byte = {rx_q[6:0], mosi_s};
    assign rd_addr = (state_q == ST_CMD) ? rx_byte[6:0] : addr_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        skip_d    = skip_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        rd_slot_d = 1'b0;
        ld_d      = 1'b0;
        ld_int_d  = 1'b0;
        ferr_d    = 1'b0;
        clr       = '0;

        if (wr_q || rd_slot_q) begin
            addr_d = addr_q + 7'd1;
        end
        // A read slot without REG_RD is the internal interrupt register
        if (rd_slot_q) begin
            ld_d     = 1'b1;
            ld_int_d = ~rd_q;
        end

        if (ld_q) begin
            tx_d   = ld_int_q ? pend_q : REG_RDATA;
            clr    = ld_int_q ? pend_q : '0;
            skip_d = 1'b1;
        end else if (sclk_fall && state_q == ST_DATA) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (nss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    skip_d    = 1'b0;
                end
            end
            ST_CMD, ST_DATA: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_CMD) begin
                            state_d   = ST_DATA;
                            rw_d      = rx_byte[7];
                            addr_d    = rx_byte[6:0];
                            rd_slot_d = rx_byte[7];
                            rd_d      = rx_byte[7] && (rd_addr != INT_ADDR);
                        end else if (rw_q) begin
                            rd_slot_d = 1'b1;
                            rd_d      = (rd_addr != INT_ADDR);
                        end else begin
                            wr_d    = 1'b1;
                            wdata_d = rx_byte;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (nss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            ferr_d    = (bit_cnt_q != 3'd0);
            wr_d      = 1'b0;
            rd_d      = 1'b0;
            rd_slot_d = 1'b0;
        end

        pend_d = (pend_q & ~clr) | IRQ_IN;
        int_d  = |pend_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            skip_q    <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            rd_slot_q <= 1'b0;
            ld_q      <= 1'b0;
            ld_int_q  <= 1'b0;
            pend_q    <= '0;
            int_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            skip_q    <= skip_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            rd_slot_q <= rd_slot_d;
            ld_q      <= ld_d;
            ld_int_q  <= ld_int_d;
            pend_q    <= pend_d;
            int_q     <= int_d;
            ferr_q    <= ferr_d;
        end
    end

    assign SPI_MISO_OE  = (state_q != ST_IDLE);
    assign SPI_MISO_OUT = (state_q == ST_DATA) & tx_q[7];
    assign SPI_INT_OUT  = int_q;
    assign REG_ADDR     = addr_q;
    assign REG_WR       = wr_q;
    assign REG_WDATA    = wdata_q;
    assign REG_RD       = rd_q;
    assign FRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_fpga_spi_target.sv
// Bench for fpga_spi_target: acts as MCU master and register fabric, and checks
// strobes, MISO bytes and interrupt behaviour against a frame-level model.
module tb_fpga_spi_target;

    localparam int H = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SPI_CLK_IN, SPI_MOSI_IN, SPI_NSS_IN;
    logic       SPI_MISO_OUT, SPI_MISO_OE, SPI_INT_OUT;
    logic [6:0] REG_ADDR;
    logic       REG_WR, REG_RD, FRAME_ERR;
    logic [7:0] REG_WDATA, REG_RDATA, IRQ_IN;

    fpga_spi_target #(.SYNC_STAGES(2), .INT_ADDR(7'h7F)) dut (
        .CLK(CLK), .RST(RST),
        .SPI_CLK_IN(SPI_CLK_IN), .SPI_MOSI_IN(SPI_MOSI_IN), .SPI_NSS_IN(SPI_NSS_IN),
        .SPI_MISO_OUT(SPI_MISO_OUT), .SPI_MISO_OE(SPI_MISO_OE), .SPI_INT_OUT(SPI_INT_OUT),
        .REG_ADDR(REG_ADDR), .REG_WR(REG_WR), .REG_WDATA(REG_WDATA),
        .REG_RD(REG_RD), .REG_RDATA(REG_RDATA), .IRQ_IN(IRQ_IN), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int chk = 0;
    int err = 0;

    logic [7:0] fab_mem [128];
    logic [7:0] ref_mem [128];
    logic [7:0] pend_model = '0;
    logic       rd_prev = 1'b0;
    logic [6:0] rd_addr_prev = '0;

    logic [6:0] wr_log_a [$];
    logic [7:0] wr_log_d [$];
    logic [6:0] rd_log   [$];
    int         ferr_cnt = 0;

    logic [6:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [6:0] exp_ra [$];
    logic [7:0] exp_rx [8];

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [7:0] irq_hook = '0;

    // Fabric: read data is valid only in the cycle after REG_RD, garbage otherwise
    always @(negedge CLK) begin
        REG_RDATA = rd_prev ? fab_mem[rd_addr_prev] : 8'($urandom);
        rd_prev = REG_RD;
        rd_addr_prev = REG_ADDR;
        if (REG_WR === 1'b1) begin
            wr_log_a.push_back(REG_ADDR);
            wr_log_d.push_back(REG_WDATA);
            fab_mem[REG_ADDR] = REG_WDATA;
        end
        if (REG_RD === 1'b1) rd_log.push_back(REG_ADDR);
        if (FRAME_ERR === 1'b1) ferr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic [7:0] irq_load,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            SPI_MOSI_IN = tx[i];
            repeat (H) @(negedge CLK);
            rx[i] = SPI_MISO_OUT;
            SPI_CLK_IN = 1'b1;
            for (int j = 1; j <= H; j++) begin
                @(negedge CLK);
                if (i == 0 && irq_load != 0) begin
                    if (j == 4) IRQ_IN = irq_load;
                    else if (j == 5) IRQ_IN = '0;
                end
            end
            SPI_CLK_IN = 1'b0;
        end
    endtask

    task automatic do_frame(input int nbytes, input int partial_bits);
        logic [7:0] dummy;
        SPI_NSS_IN = 1'b0;
        repeat (H) @(negedge CLK);
        check("oe_in_frame", SPI_MISO_OE, 1);
        for (int b = 0; b < nbytes; b++)
            spi_xfer(tx_buf[b], 8, (b == 0) ? irq_hook : 8'h00, rx_buf[b]);
        if (partial_bits > 0) spi_xfer(tx_buf[nbytes], partial_bits, 8'h00, dummy);
        repeat (H) @(negedge CLK);
        SPI_NSS_IN = 1'b1;
        repeat (2 * H) @(negedge CLK);
    endtask

    // Frame-level model: command byte then auto-incrementing data bytes
    task automatic model_frame(input int nbytes);
        logic       rw;
        int         a, sa;
        logic [7:0] slot_val [8];
        rw = tx_buf[0][7];
        a  = int'(tx_buf[0][6:0]);
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        for (int k = 0; k < 8; k++) exp_rx[k] = '0;
        if (!rw) begin
            for (int i = 1; i < nbytes; i++) begin
                sa = (a + i - 1) % 128;
                exp_wa.push_back(7'(sa));
                exp_wd.push_back(tx_buf[i]);
                ref_mem[sa] = tx_buf[i];
            end
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                sa = (a + i) % 128;
                if (sa == 127) begin
                    slot_val[i] = pend_model;
                    pend_model = '0;
                end else begin
                    exp_ra.push_back(7'(sa));
                    slot_val[i] = ref_mem[sa];
                end
            end
            for (int k = 1; k < nbytes; k++) exp_rx[k] = slot_val[k-1];
        end
    endtask

    task automatic check_frame(input string tag, input int nbytes, input int exp_ferr);
        logic [31:0] obs;
        check($sformatf("%s_cmd_miso", tag), rx_buf[0], 0);
        check($sformatf("%s_wr_count", tag), wr_log_a.size(), exp_wa.size());
        foreach (exp_wa[k]) begin
            obs = (k < wr_log_a.size()) ? 32'(wr_log_a[k]) : 'x;
            check($sformatf("%s_wr_addr%0d", tag, k), obs, exp_wa[k]);
            obs = (k < wr_log_d.size()) ? 32'(wr_log_d[k]) : 'x;
            check($sformatf("%s_wr_data%0d", tag, k), obs, exp_wd[k]);
        end
        check($sformatf("%s_rd_count", tag), rd_log.size(), exp_ra.size());
        foreach (exp_ra[k]) begin
            obs = (k < rd_log.size()) ? 32'(rd_log[k]) : 'x;
            check($sformatf("%s_rd_addr%0d", tag, k), obs, exp_ra[k]);
        end
        if (tx_buf[0][7])
            for (int k = 1; k < nbytes; k++)
                check($sformatf("%s_miso%0d", tag, k), rx_buf[k], exp_rx[k]);
        check($sformatf("%s_frame_err", tag), ferr_cnt, exp_ferr);
        wr_log_a.delete(); wr_log_d.delete(); rd_log.delete();
        ferr_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, SPI_MISO_OUT, 0);
        check({tag, "_oe"}, SPI_MISO_OE, 0);
        check({tag, "_int"}, SPI_INT_OUT, 0);
        check({tag, "_addr"}, REG_ADDR, 0);
        check({tag, "_wr"}, REG_WR, 0);
        check({tag, "_wdata"}, REG_WDATA, 0);
        check({tag, "_rd"}, REG_RD, 0);
        check({tag, "_ferr"}, FRAME_ERR, 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] dummy;
        logic       rw;
        logic [6:0] ad;
        int         nb;

        RST = 1'b1; SPI_CLK_IN = 1'b0; SPI_MOSI_IN = 1'b0; SPI_NSS_IN = 1'b1; IRQ_IN = '0;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            fab_mem[i] = v;
            ref_mem[i] = v;
        end
        fab_mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b0;
        repeat (2 * H) @(negedge CLK);
        check_outputs_zero("post_reset");
        wr_log_a.delete(); wr_log_d.delete(); rd_log.delete(); ferr_cnt = 0;

        // Single write
        tx_buf[0] = 8'h12; tx_buf[1] = 8'hA5;
        model_frame(2); do_frame(2, 0); check_frame("wr1", 2, 0);

        // Single read with prefetch
        tx_buf[0] = 8'h85; tx_buf[1] = 8'h00;
        model_frame(2); do_frame(2, 0); check_frame("rd1", 2, 0);

        // Burst write across address wrap
        tx_buf[0] = 8'h7E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
        model_frame(4); do_frame(4, 0); check_frame("wrap", 4, 0);

        // Abort on a partial byte, then a normal frame
        tx_buf[0] = 8'h10; tx_buf[1] = 8'hC3;
        model_frame(1); do_frame(1, 3); check_frame("abort", 1, 1);
        tx_buf[0] = 8'h10; tx_buf[1] = 8'h77;
        model_frame(2); do_frame(2, 0); check_frame("after_abort", 2, 0);

        // Interrupt: flag, read-clear, and a new source in the clearing cycle
        check("int_idle", SPI_INT_OUT, 0);
        IRQ_IN = 8'h04; @(negedge CLK); IRQ_IN = '0;
        pend_model = pend_model | 8'h04;
        repeat (3) @(negedge CLK);
        check("int_set", SPI_INT_OUT, 1);
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00;
        model_frame(2);
        pend_model = pend_model | 8'h01;
        irq_hook = 8'h01;
        do_frame(2, 0);
        irq_hook = 8'h00;
        check_frame("int_rd1", 2, 0);
        check("int_kept", SPI_INT_OUT, 1);
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00;
        model_frame(2); do_frame(2, 0); check_frame("int_rd2", 2, 0);
        check("int_cleared", SPI_INT_OUT, 0);

        // Reset in the middle of a command byte
        SPI_NSS_IN = 1'b0;
        repeat (H) @(negedge CLK);
        spi_xfer(8'hA0, 4, 8'h00, dummy);
        RST = 1'b1;
        @(negedge CLK);
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (H) @(negedge CLK);
        spi_xfer(8'h12, 8, 8'h00, dummy);
        spi_xfer(8'h34, 8, 8'h00, dummy);
        check("no_frame_oe", SPI_MISO_OE, 0);
        check("no_frame_wr", wr_log_a.size(), 0);
        check("no_frame_rd", rd_log.size(), 0);
        check("no_frame_ferr", ferr_cnt, 0);
        SPI_NSS_IN = 1'b1;
        repeat (2 * H) @(negedge CLK);
        wr_log_a.delete(); wr_log_d.delete(); rd_log.delete(); ferr_cnt = 0;
        tx_buf[0] = 8'h33; tx_buf[1] = 8'h5A;
        model_frame(2); do_frame(2, 0); check_frame("post_rst_wr", 2, 0);

        // Randomised frames
        for (int r = 0; r < 10; r++) begin
            rw = 1'($urandom_range(0, 1));
            ad = (r == 0) ? 7'h7D : 7'($urandom_range(0, 127));
            nb = 2 + int'($urandom_range(0, 3));
            tx_buf[0] = {rw, ad};
            for (int k = 1; k < nb; k++) tx_buf[k] = 8'($urandom);
            model_frame(nb); do_frame(nb, 0);
            check_frame($sformatf("rnd%0d", r), nb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
